id_ex_stage: RTL



---
 rtl/id_ex_stage_pkg.sv | 26 ++
 rtl/id_ex_stage_fwd_sel.sv | 28 ++
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and bubble values for the ID/EX pipeline register.
// Used by both the top-level stage and the forwarding selector.
package id_ex_stage_pkg;

   // REWR_MUX: what the instruction writes back.
   localparam logic [1:0] REWR_NONE   = 2'b00;
   localparam logic [1:0] REWR_LOAD   = 2'b01;
   localparam logic [1:0] REWR_ALU    = 2'b10;
   localparam logic [1:0] REWR_BRANCH = 2'b11;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_t;

   // Control values that make the EX slot architecturally inert.
   localparam logic       BUBBLE_RF_WE     = 1'b0;
   localparam logic       BUBBLE_D_MEM_WEN = 1'b1;
   localparam logic [3:0] BUBBLE_D_MEM_BE  = 4'b0000;
   localparam logic [1:0] BUBBLE_REWR_MUX  = REWR_NONE;
   localparam logic [4:0] BUBBLE_RD        = 5'd0;
   localparam logic       BUBBLE_PCMUX     = 1'b0;
   localparam logic       BUBBLE_ISJALR    = 1'b0;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Forward-select for one source operand: EX/MEM producer wins over MEM/WB.
// Register x0 is never forwarded.
import id_ex_stage_pkg::*;

module fwd_sel (
   input  logic       use_rs,
   input  logic [4:0] rs,
   input  logic       ex_rf_we,
   input  logic [4:0] ex_rd,
   input  logic       mem_rf_we,
   input  logic [4:0] mem_rd,
   output logic [1:0] fwd
);

   logic live;

   assign live = use_rs && (rs != 5'd0);

   always_comb begin
      fwd = FWD_RF;
      if (live && ex_rf_we && (rs == ex_rd)) begin
         fwd = FWD_EXMEM;
      end else if (live && mem_rf_we && (rs == mem_rd)) begin
         fwd = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion for load-use stalls and
// wrong-path squash, registered operand-forward selects and an instruction counter.
import id_ex_stage_pkg::*;

module id_ex_stage (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        IR_WR,
   input  logic        FLUSH,
   input  logic        NUMINSTADD,
   input  logic        RF_WE,
   input  logic        D_MEM_WEN,
   input  logic        AMUX,
   input  logic        ISJALR,
   input  logic        CONDMUX,
   input  logic        PCMUX,
   input  logic [3:0]  D_MEM_BE,
   input  logic [1:0]  BMUX,
   input  logic [1:0]  REWR_MUX,
   input  logic [6:0]  ALU_CONTROL,
   input  logic        USE_RS1_IN,
   input  logic        USE_RS2_IN,
   input  logic [31:0] PC_IN,
   input  logic [31:0] RS1_DATA,
   input  logic [31:0] RS2_DATA,
   input  logic [31:0] IMM,
   input  logic [4:0]  RS1,
   input  logic [4:0]  RS2,
   input  logic [4:0]  RD,
   input  logic [4:0]  MEM_RD,
   input  logic        MEM_RF_WE,
   output logic        EX_RF_WE,
   output logic        EX_D_MEM_WEN,
   output logic        EX_AMUX,
   output logic        EX_ISJALR,
   output logic        EX_CONDMUX,
   output logic        EX_PCMUX,
   output logic [3:0]  EX_D_MEM_BE,
   output logic [1:0]  EX_BMUX,
   output logic [1:0]  EX_REWR_MUX,
   output logic [6:0]  EX_ALU_CONTROL,
   output logic        EX_USE_RS1,
   output logic        EX_USE_RS2,
   output logic [31:0] EX_PC,
   output logic [31:0] EX_RS1_DATA,
   output logic [31:0] EX_RS2_DATA,
   output logic [31:0] EX_IMM,
   output logic [4:0]  EX_RS1,
   output logic [4:0]  EX_RS2,
   output logic [4:0]  EX_RD,
   output logic        EX_VALID,
   output logic [1:0]  FWD_A,
   output logic [1:0]  FWD_B,
   output logic [4:0]  PREV_DEST,
   output logic [1:0]  PREV_REWR_MUX,
   output logic [31:0] NUM_INST
);

   logic        squash_pending_reg;
   logic [31:0] num_inst_reg;
   logic        capture;
   logic [1:0]  fwd_a_next;
   logic [1:0]  fwd_b_next;

   assign capture = IR_WR && !squash_pending_reg;

   // Compared against the instruction currently in EX, i.e. the one ahead.
   fwd_sel u_fwd_a (
      .use_rs    (USE_RS1_IN),
      .rs        (RS1),
      .ex_rf_we  (EX_RF_WE),
      .ex_rd     (EX_RD),
      .mem_rf_we (MEM_RF_WE),
      .mem_rd    (MEM_RD),
      .fwd       (fwd_a_next)
   );

   fwd_sel u_fwd_b (
      .use_rs    (USE_RS2_IN),
      .rs        (RS2),
      .ex_rf_we  (EX_RF_WE),
      .ex_rd     (EX_RD),
      .mem_rf_we (MEM_RF_WE),
      .mem_rd    (MEM_RD),
      .fwd       (fwd_b_next)
   );

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         squash_pending_reg <= 1'b0;
         num_inst_reg       <= 32'd0;
         EX_RF_WE           <= 1'b0;
         EX_D_MEM_WEN       <= 1'b1;
         EX_AMUX            <= 1'b0;
         EX_ISJALR          <= 1'b0;
         EX_CONDMUX         <= 1'b0;
         EX_PCMUX           <= 1'b0;
         EX_D_MEM_BE        <= 4'd0;
         EX_BMUX            <= 2'd0;
         EX_REWR_MUX        <= 2'd0;
         EX_ALU_CONTROL     <= 7'd0;
         EX_USE_RS1         <= 1'b0;
         EX_USE_RS2         <= 1'b0;
         EX_PC              <= 32'd0;
         EX_RS1_DATA        <= 32'd0;
         EX_RS2_DATA        <= 32'd0;
         EX_IMM             <= 32'd0;
         EX_RS1             <= 5'd0;
         EX_RS2             <= 5'd0;
         EX_RD              <= 5'd0;
         EX_VALID           <= 1'b0;
         FWD_A              <= FWD_RF;
         FWD_B              <= FWD_RF;
      end else if (capture) begin
         // A captured branch/jump marks its fetched successor as wrong-path.
         squash_pending_reg <= FLUSH;
         if (NUMINSTADD) begin
            num_inst_reg <= num_inst_reg + 32'd1;
         end
         EX_RF_WE       <= RF_WE;
         EX_D_MEM_WEN   <= D_MEM_WEN;
         EX_AMUX        <= AMUX;
         EX_ISJALR      <= ISJALR;
         EX_CONDMUX     <= CONDMUX;
         EX_PCMUX       <= PCMUX;
         EX_D_MEM_BE    <= D_MEM_BE;
         EX_BMUX        <= BMUX;
         EX_REWR_MUX    <= REWR_MUX;
         EX_ALU_CONTROL <= ALU_CONTROL;
         EX_USE_RS1     <= USE_RS1_IN;
         EX_USE_RS2     <= USE_RS2_IN;
         EX_PC          <= PC_IN;
         EX_RS1_DATA    <= RS1_DATA;
         EX_RS2_DATA    <= RS2_DATA;
         EX_IMM         <= IMM;
         EX_RS1         <= RS1;
         EX_RS2         <= RS2;
         EX_RD          <= RD;
         EX_VALID       <= NUMINSTADD;
         FWD_A          <= fwd_a_next;
         FWD_B          <= fwd_b_next;
      end else begin
         // Squash survives stalls and is consumed by the first advancing edge.
         if (IR_WR) begin
            squash_pending_reg <= 1'b0;
         end
         EX_RF_WE     <= BUBBLE_RF_WE;
         EX_D_MEM_WEN <= BUBBLE_D_MEM_WEN;
         EX_D_MEM_BE  <= BUBBLE_D_MEM_BE;
         EX_REWR_MUX  <= BUBBLE_REWR_MUX;
         EX_RD        <= BUBBLE_RD;
         EX_PCMUX     <= BUBBLE_PCMUX;
         EX_ISJALR    <= BUBBLE_ISJALR;
         EX_VALID     <= 1'b0;
         FWD_A        <= FWD_RF;
         FWD_B        <= FWD_RF;
      end
   end

   assign PREV_DEST     = EX_RD;
   assign PREV_REWR_MUX = EX_REWR_MUX;
   assign NUM_INST      = num_inst_reg;

endmodule
